// File: rtl/fir_pkg.sv
// Shared types, default RRC coefficient set and helpers for fir_filter_param.
// The typedefs describe the default 7-bit sample / 9-bit coefficient build.
// Parameterised instances size their own signals from module localparams.
package fir_pkg;

   localparam int RRC_DATA_W = 7;
   localparam int RRC_COEF_W = 9;
   localparam int RRC_NTAPS  = 33;

   typedef logic signed [RRC_DATA_W-1:0] sample_t;
   typedef logic signed [RRC_COEF_W-1:0] coef_t;
   typedef logic signed [RRC_DATA_W+RRC_COEF_W+$clog2(RRC_NTAPS)-1:0] acc_t;

   // Symmetric 33-tap RRC pulse-shaping response, centre tap at index 16.
   localparam coef_t RRC33_COEFS [RRC_NTAPS] = '{
      9'sd0,  -9'sd1,   9'sd1,   9'sd0,  -9'sd1,   9'sd2,   9'sd0,  -9'sd2,
      9'sd2,   9'sd0,  -9'sd6,   9'sd8,   9'sd10, -9'sd28, -9'sd14,  9'sd111,
      9'sd196,
      9'sd111, -9'sd14, -9'sd28,  9'sd10,  9'sd8,  -9'sd6,   9'sd0,   9'sd2,
      -9'sd2,   9'sd0,   9'sd2,  -9'sd1,   9'sd0,   9'sd1,  -9'sd1,   9'sd0
   };

   // Ceiling division; gives the number of partial-sum groups.
   function automatic int clog2_ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: writes land in the shadow bank, a
// commit copies the whole shadow bank into the active bank used by the
// multipliers. Both banks reset to the RRC set for 33 taps, else zeros.
module fir_coef_bank
   import fir_pkg::*;
#(
   parameter int NTAPS  = 33,
   parameter int COEF_W = 9,
   parameter int ADDR_W = $clog2(NTAPS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      coef_we,
   input  logic [ADDR_W-1:0]         coef_addr,
   input  logic signed [COEF_W-1:0]  coef_wdata,
   input  logic                      coef_commit,
   output logic [NTAPS*COEF_W-1:0]   active_flat
);

   logic signed [COEF_W-1:0] shadow [NTAPS];
   logic signed [COEF_W-1:0] active [NTAPS];

   function automatic logic signed [COEF_W-1:0] default_coef(input int idx);
      if (NTAPS == 33) return COEF_W'(RRC33_COEFS[idx]);
      return '0;
   endfunction

   // Shadow write and commit; commit sees the shadow contents from before
   // a same-cycle write because both use the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NTAPS; i++) begin
            shadow[i] <= default_coef(i);
            active[i] <= default_coef(i);
         end
      end else begin
         if (coef_we && (32'(coef_addr) < NTAPS)) shadow[coef_addr] <= coef_wdata;
         if (coef_commit) begin
            for (int i = 0; i < NTAPS; i++) active[i] <= shadow[i];
         end
      end
   end

   for (genvar g = 0; g < NTAPS; g++) begin : g_flat
      assign active_flat[g*COEF_W +: COEF_W] = active[g];
   end

endmodule

// File: rtl/fir_filter_param.sv
// Pipelined run-time-programmable direct-form FIR.
// Stages: delay line -> products -> grouped partial sums -> total, shift,
// saturate. Four cycles from accepted sample to out_valid.
// Optional macro FIR_ROUND_EN: add half an LSB before the final shift
// (round half up); without it the shift truncates toward minus infinity.
module fir_filter_param
   import fir_pkg::*;
#(
   parameter int DATA_W     = 7,
   parameter int COEF_W     = 9,
   parameter int NTAPS      = 33,
   parameter int GROUP      = 8,
   parameter int FRAC_SHIFT = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic signed [DATA_W-1:0]   in_data,
   input  logic                       flush,
   input  logic                       coef_we,
   input  logic [$clog2(NTAPS)-1:0]   coef_addr,
   input  logic signed [COEF_W-1:0]   coef_wdata,
   input  logic                       coef_commit,
   output logic                       out_valid,
   output logic signed [DATA_W-1:0]   out_data,
   output logic                       sat_flag,
   input  logic                       sat_clr,
   output logic [15:0]                sat_count
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int PSUM_W = PROD_W + $clog2(GROUP);
   localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS);
   localparam int NG     = clog2_ceil_div(NTAPS, GROUP);

   localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W-1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   logic [NTAPS*COEF_W-1:0]  active_flat;
   logic signed [COEF_W-1:0] coef [NTAPS];
   logic signed [DATA_W-1:0] taps [NTAPS];
   logic signed [PROD_W-1:0] prod [NTAPS];
   logic signed [PSUM_W-1:0] psum [NG];
   logic signed [PSUM_W-1:0] psum_next [NG];
   logic                     tap_valid, prod_valid, psum_valid;
   logic signed [ACC_W-1:0]  acc, acc_rnd, acc_shift;
   logic                     clip_hi, clip_lo;
   logic signed [DATA_W-1:0] sat_data;

   fir_coef_bank #(
      .NTAPS  (NTAPS),
      .COEF_W (COEF_W),
      .ADDR_W ($clog2(NTAPS))
   ) u_coef_bank (
      .clk         (clk),
      .rst         (rst),
      .coef_we     (coef_we),
      .coef_addr   (coef_addr),
      .coef_wdata  (coef_wdata),
      .coef_commit (coef_commit),
      .active_flat (active_flat)
   );

   for (genvar g = 0; g < NTAPS; g++) begin : g_coef
      assign coef[g] = active_flat[g*COEF_W +: COEF_W];
   end

   // Delay line: shifts on valid samples; flush zeroes it, keeping a
   // same-cycle sample in tap 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         tap_valid <= 1'b0;
         for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
      end else begin
         tap_valid <= in_valid;
         if (flush) begin
            for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
            if (in_valid) taps[0] <= in_data;
         end else if (in_valid) begin
            taps[0] <= in_data;
            for (int i = 1; i < NTAPS; i++) taps[i] <= taps[i-1];
         end
      end
   end

   // S1: one registered product per tap.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_valid <= 1'b0;
         for (int i = 0; i < NTAPS; i++) prod[i] <= '0;
      end else begin
         prod_valid <= tap_valid;
         if (tap_valid) begin
            for (int i = 0; i < NTAPS; i++) prod[i] <= PROD_W'(taps[i]) * PROD_W'(coef[i]);
         end
      end
   end

   // S2 adder trees: GROUP products per partial sum, last group may be short.
   always_comb begin
      for (int g = 0; g < NG; g++) begin
         psum_next[g] = '0;
         for (int j = 0; j < GROUP; j++) begin
            if (g*GROUP + j < NTAPS) psum_next[g] = psum_next[g] + PSUM_W'(prod[g*GROUP + j]);
         end
      end
   end

   // S2 register.
   always_ff @(posedge clk) begin
      if (rst) begin
         psum_valid <= 1'b0;
         for (int g = 0; g < NG; g++) psum[g] <= '0;
      end else begin
         psum_valid <= prod_valid;
         if (prod_valid) begin
            for (int g = 0; g < NG; g++) psum[g] <= psum_next[g];
         end
      end
   end

   // S3 combinational: total, optional rounding, shift and clip.
   always_comb begin
      acc = '0;
      for (int g = 0; g < NG; g++) acc = acc + ACC_W'(psum[g]);
`ifdef FIR_ROUND_EN
      acc_rnd = acc + (ACC_W'(1) <<< (FRAC_SHIFT-1));
`else
      acc_rnd = acc;
`endif
      acc_shift = acc_rnd >>> FRAC_SHIFT;
      clip_hi   = acc_shift > SAT_MAX;
      clip_lo   = acc_shift < SAT_MIN;
      if (clip_hi)      sat_data = DATA_W'(SAT_MAX);
      else if (clip_lo) sat_data = DATA_W'(SAT_MIN);
      else              sat_data = acc_shift[DATA_W-1:0];
   end

   // S3 output register; data holds between valid outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= psum_valid;
         if (psum_valid) out_data <= sat_data;
      end
   end

   // Saturation monitor; a clear beats a coincident clip.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_flag  <= 1'b0;
         sat_count <= '0;
      end else if (sat_clr) begin
         sat_flag  <= 1'b0;
         sat_count <= '0;
      end else if (psum_valid && (clip_hi || clip_lo)) begin
         sat_flag <= 1'b1;
         if (sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_fir_filter_param.sv
module tb_fir_filter_param;

   localparam int DATA_W = 7;
   localparam int COEF_W = 9;
   localparam int NTAPS  = 33;
   localparam int AW     = $clog2(NTAPS);

   logic clk = 1'b0;
   logic rst, in_valid, flush, coef_we, coef_commit, sat_clr, out_valid, sat_flag;
   logic signed [DATA_W-1:0] in_data, out_data;
   logic [AW-1:0] coef_addr;
   logic signed [COEF_W-1:0] coef_wdata;
   logic [15:0] sat_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int out_val_q[$];
   int out_cyc_q[$];
   int in_cyc_q[$];
   logic hold_en = 1'b0;
   int last_out = 0;

   typedef struct {
      logic signed [DATA_W-1:0] din;
      int                       exp_out;
   } vec_t;
   vec_t imp_tab [34];

   // Impulse of 63 through the RRC taps 0..16 (response is mirrored).
`ifdef FIR_ROUND_EN
   localparam int HALF [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 2, 2, -7, -3, 27, 48};
   localparam int EXP_C64  = 16;
   localparam int EXP_CP32 = 8;
   localparam int EXP_CM32 = -8;
`else
   localparam int HALF [17] = '{0, -1, 0, 0, -1, 0, 0, -1, 0, 0, -2, 1, 2, -7, -4, 27, 48};
   localparam int EXP_C64  = 15;
   localparam int EXP_CP32 = 7;
   localparam int EXP_CM32 = -8;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fir_filter_param dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .flush       (flush),
      .coef_we     (coef_we),
      .coef_addr   (coef_addr),
      .coef_wdata  (coef_wdata),
      .coef_commit (coef_commit),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .sat_flag    (sat_flag),
      .sat_clr     (sat_clr),
      .sat_count   (sat_count)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic chk_q(input string name, input int idx, input int req);
      if (idx < out_val_q.size()) chk(name, out_val_q[idx], req);
      else begin
         checks++;
         errors++;
         $display("FAIL %s: output %0d never arrived, expected %0d", name, idx, req);
      end
   endtask

   // Output collector; also checks that out_data holds between valid outputs.
   always @(negedge clk) begin
      if (rst) last_out = 0;
      else if (out_valid) begin
         out_val_q.push_back(int'(out_data));
         out_cyc_q.push_back(cyc);
         last_out = int'(out_data);
      end else if (hold_en) chk("hold_out_data", int'(out_data), last_out);
   end

   task automatic clear_q();
      out_val_q.delete();
      out_cyc_q.delete();
      in_cyc_q.delete();
   endtask

   task automatic drive(input logic v, input int d, input logic f);
      @(negedge clk);
      in_valid = v;
      in_data  = DATA_W'(d);
      flush    = f;
      if (v) in_cyc_q.push_back(cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
      coef_we = 1'b0; coef_commit = 1'b0; sat_clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_q();
   endtask

   task automatic coef_op(input logic we, input int addr, input int data, input logic commit);
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      coef_we = we; coef_addr = AW'(addr); coef_wdata = COEF_W'(data); coef_commit = commit;
      @(negedge clk);
      coef_we = 1'b0; coef_commit = 1'b0;
   endtask

   task automatic run_impulse(input int gap);
      clear_q();
      for (int k = 0; k < 34; k++) begin
         drive(1'b1, int'(imp_tab[k].din), 1'b0);
         repeat (gap) drive(1'b0, 0, 1'b0);
      end
      idle(8);
   endtask

   task automatic check_impulse(input string tag);
      chk({tag, "_count"}, out_val_q.size(), 34);
      if (out_val_q.size() == 34) begin
         for (int k = 0; k < 33; k++) begin
            chk($sformatf("%s_val[%0d]", tag, k), out_val_q[k], imp_tab[k].exp_out);
            chk($sformatf("%s_lat[%0d]", tag, k), out_cyc_q[k] - in_cyc_q[k], 4);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 34; k++) begin
         imp_tab[k].din = (k == 0) ? 7'sd63 : 7'sd0;
         if (k <= 16)      imp_tab[k].exp_out = HALF[k];
         else if (k <= 32) imp_tab[k].exp_out = HALF[32-k];
         else              imp_tab[k].exp_out = 0;
      end

      rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
      coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; coef_commit = 1'b0; sat_clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_data", int'(out_data), 0);
      chk("reset_sat_flag", int'(sat_flag), 0);
      chk("reset_sat_count", int'(sat_count), 0);
      rst = 1'b0;
      clear_q();

      // Impulse response, back-to-back samples.
      run_impulse(0);
      check_impulse("imp");

      // Impulse with in_valid pattern 1,0,0,1,...
      do_reset();
      hold_en = 1'b1;
      run_impulse(2);
      hold_en = 1'b0;
      check_impulse("gap");

      // Positive saturation on a constant 63 stream.
      do_reset();
      for (int k = 0; k < 40; k++) drive(1'b1, 63, 1'b0);
      idle(8);
      chk("satp_count_out", out_val_q.size(), 40);
      chk_q("satp_out15", 15, 20);
      chk_q("satp_out16", 16, 63);
      chk_q("satp_out39", 39, 63);
      chk("satp_flag", int'(sat_flag), 1);
      chk("satp_sat_count", int'(sat_count), 24);

      // Negative saturation, then sat_clr coinciding with a clip.
      clear_q();
      for (int k = 0; k < 40; k++) drive(1'b1, -64, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; in_data = -7'sd64; sat_clr = 1'b1;
      @(negedge clk);
      sat_clr = 1'b0;
      chk("clr_wins_flag", int'(sat_flag), 0);
      chk("clr_wins_count", int'(sat_count), 0);
      @(negedge clk);
      chk("after_clr_flag", int'(sat_flag), 1);
      chk("after_clr_count", int'(sat_count), 1);
      idle(8);
      chk_q("satn_last", out_val_q.size() - 1, -64);
      @(negedge clk);
      sat_clr = 1'b1;
      @(negedge clk);
      sat_clr = 1'b0;
      chk("clr_flag", int'(sat_flag), 0);
      chk("clr_count", int'(sat_count), 0);

      // Coefficient double buffering.
      do_reset();
      coef_op(1'b1, 16, 64, 1'b0);
      run_impulse(0);
      chk_q("shadow_only_c16", 16, 48);
      coef_op(1'b0, 0, 0, 1'b1);
      run_impulse(0);
      chk_q("commit_c16", 16, EXP_C64);
      chk_q("commit_c15", 15, 27);
      coef_op(1'b1, 16, 32, 1'b0);
      coef_op(1'b1, 16, -32, 1'b1);
      run_impulse(0);
      chk_q("we_commit_c16", 16, EXP_CP32);
      coef_op(1'b0, 0, 0, 1'b1);
      run_impulse(0);
      chk_q("second_commit_c16", 16, EXP_CM32);

      // Reset in the middle of an impulse; coefficients revert.
      clear_q();
      for (int k = 0; k < 6; k++) drive(1'b1, (k == 0) ? 63 : 0, 1'b0);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_out_data", int'(out_data), 0);
      rst = 1'b0;
      clear_q();
      idle(8);
      chk("midrst_no_stale", out_val_q.size(), 0);
      run_impulse(0);
      chk_q("midrst_c16", 16, 48);
      chk_q("midrst_c15", 15, 27);

      // Flush with a same-cycle sample after a constant stream.
      do_reset();
      for (int k = 0; k < 40; k++) drive(1'b1, 63, 1'b0);
      drive(1'b1, 63, 1'b1);
      for (int k = 0; k < 33; k++) drive(1'b1, 0, 1'b0);
      idle(8);
      chk("flush_count", out_val_q.size(), 74);
      chk_q("flush_inflight", 39, 63);
      for (int k = 0; k < 33; k++) chk_q($sformatf("flush_imp[%0d]", k), 40 + k, imp_tab[k].exp_out);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
